// File: rtl/mem_1r1w_ctrl_if.sv
// Bus bundle between mem_1r1w_ctrl, its two read clients, its write client and the 1R1W macro.
// The slave modport is the controller's view; master is the surrounding system.
interface mem_1r1w_ctrl_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 6
);
  logic              clear_req;
  logic              clear_busy;

  logic              rd0_req_valid;
  logic              rd0_req_ready;
  logic [ADDR_W-1:0] rd0_req_addr;
  logic              rd0_resp_valid;
  logic [WIDTH-1:0]  rd0_resp_data;

  logic              rd1_req_valid;
  logic              rd1_req_ready;
  logic [ADDR_W-1:0] rd1_req_addr;
  logic              rd1_resp_valid;
  logic [WIDTH-1:0]  rd1_resp_data;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [WIDTH-1:0]  R0_data;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [WIDTH-1:0]  W0_data;

  modport slave (
    input  clear_req,
    output clear_busy,
    input  rd0_req_valid, rd0_req_addr,
    output rd0_req_ready, rd0_resp_valid, rd0_resp_data,
    input  rd1_req_valid, rd1_req_addr,
    output rd1_req_ready, rd1_resp_valid, rd1_resp_data,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    output R0_addr, R0_en,
    input  R0_data,
    output W0_addr, W0_en, W0_data
  );

  modport master (
    output clear_req,
    input  clear_busy,
    output rd0_req_valid, rd0_req_addr,
    input  rd0_req_ready, rd0_resp_valid, rd0_resp_data,
    output rd1_req_valid, rd1_req_addr,
    input  rd1_req_ready, rd1_resp_valid, rd1_resp_data,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    input  R0_addr, R0_en,
    output R0_data,
    input  W0_addr, W0_en, W0_data
  );
endinterface

// File: rtl/mem_1r1w_ctrl.sv
// Front-end for a 1R1W synchronous SRAM: round-robin shared read port, write pass-through,
// zero-fill clear after reset or on request, write-to-read bypass and out-of-range masking.
module mem_1r1w_ctrl #(
  parameter int DEPTH  = 48,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  mem_1r1w_ctrl_if.slave   bus
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rr_ptr;
  logic              vld0_p1, vld1_p1, oob_p1, byp_p1;
  logic [WIDTH-1:0]  byp_data_p1;

  logic              run, clearing, contended;
  logic              gnt0, gnt1, gnt_any, rd_oob, wr_hit, byp_hit;
  logic [ADDR_W-1:0] gnt_addr;
  logic [WIDTH-1:0]  resp_sel;

  // p0: arbitration, write pass-through, clear sequencing
  assign run       = reset_n && (state == S_RUN);
  assign clearing  = reset_n && (state == S_CLEAR);
  assign contended = run && bus.rd0_req_valid && bus.rd1_req_valid;

  always_comb begin
    gnt0     = run && bus.rd0_req_valid && (!bus.rd1_req_valid || !rr_ptr);
    gnt1     = run && bus.rd1_req_valid && (!bus.rd0_req_valid ||  rr_ptr);
    gnt_any  = gnt0 || gnt1;
    gnt_addr = gnt1 ? bus.rd1_req_addr : bus.rd0_req_addr;
    rd_oob   = !in_range(gnt_addr);
    wr_hit   = run && bus.wr_valid && in_range(bus.wr_addr);
    // Same-cycle write to the granted address: the macro's read value would be stale.
    byp_hit  = gnt_any && !rd_oob && wr_hit && (bus.wr_addr == gnt_addr);
  end

  assign bus.rd0_req_ready = gnt0;
  assign bus.rd1_req_ready = gnt1;
  assign bus.wr_ready      = run;
  assign bus.clear_busy    = (state == S_CLEAR);

  assign bus.R0_en   = gnt_any && !rd_oob;
  assign bus.R0_addr = gnt_addr;
  assign bus.W0_en   = clearing || wr_hit;
  assign bus.W0_addr = clearing ? clr_cnt : bus.wr_addr;
  assign bus.W0_data = clearing ? '0 : bus.wr_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      rr_ptr  <= 1'b0;
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
      oob_p1  <= 1'b0;
      byp_p1  <= 1'b0;
    end else begin
      vld0_p1 <= gnt0;
      vld1_p1 <= gnt1;
      oob_p1  <= gnt_any && rd_oob;
      byp_p1  <= byp_hit;
      if (contended) rr_ptr <= ~rr_ptr;
      case (state)
        S_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= S_RUN;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (bus.clear_req) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (byp_hit) byp_data_p1 <= bus.wr_data;
  end

  // p1: response routing back to the granted requester
  always_comb begin
    if (byp_p1)      resp_sel = byp_data_p1;
    else if (oob_p1) resp_sel = '0;
    else             resp_sel = bus.R0_data;
  end

  assign bus.rd0_resp_valid = vld0_p1;
  assign bus.rd1_resp_valid = vld1_p1;
  assign bus.rd0_resp_data  = vld0_p1 ? resp_sel : '0;
  assign bus.rd1_resp_data  = vld1_p1 ? resp_sel : '0;

endmodule

// File: tb/tb_mem_1r1w_ctrl.sv
// Directed bench for mem_1r1w_ctrl with a behavioural 1R1W macro behind the controller.
module tb_mem_1r1w_ctrl;
  localparam int DEPTH  = 48;
  localparam int WIDTH  = 64;
  localparam int ADDR_W = 6;
  localparam logic [63:0] BEEF = 64'hDEADBEEF_CAFEF00D;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   nvec    = 0;
  int   nerr    = 0;

  mem_1r1w_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  mem_1r1w_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Macro model: 1-cycle read latency, old data on read-during-write, junk when not read.
  logic [WIDTH-1:0] mem [0:63];
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
      bus.R0_data <= 64'hBAD0_BAD0_BAD0_BAD0;
    end else begin
      if (bus.R0_en) bus.R0_data <= mem[bus.R0_addr];
      else           bus.R0_data <= 64'hBAD0_BAD0_BAD0_BAD0;
      if (bus.W0_en) mem[bus.W0_addr] <= bus.W0_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.clear_req     = 1'b0;
    bus.rd0_req_valid = 1'b0;
    bus.rd0_req_addr  = '0;
    bus.rd1_req_valid = 1'b0;
    bus.rd1_req_addr  = '0;
    bus.wr_valid      = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_data       = '0;
  endtask

  initial begin
    idle();
    bus.rd0_req_valid = 1'b1;
    bus.wr_valid      = 1'b1;
    bus.wr_addr       = 6'd3;
    bus.wr_data       = 64'hFF;
    #2;
    chk("rst_clear_busy", bus.clear_busy, 1);
    chk("rst_w0_en", bus.W0_en, 0);
    chk("rst_r0_en", bus.R0_en, 0);
    chk("rst_rd0_ready", bus.rd0_req_ready, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd0_resp_valid", bus.rd0_resp_valid, 0);
    chk("rst_rd0_resp_data", bus.rd0_resp_data, 0);
    tick();
    tick();
    chk("rst_hold_w0_en", bus.W0_en, 0);

    reset_n = 1'b1;
    bus.rd1_req_valid = 1'b1;
    settle();
    chk("clr0_w0_en", bus.W0_en, 1);
    chk("clr0_w0_addr", bus.W0_addr, 0);
    chk("clr0_w0_data", bus.W0_data, 0);
    chk("clr0_rd0_ready", bus.rd0_req_ready, 0);
    chk("clr0_rd1_ready", bus.rd1_req_ready, 0);
    chk("clr0_r0_en", bus.R0_en, 0);
    chk("clr0_wr_ready", bus.wr_ready, 0);
    chk("clr0_busy", bus.clear_busy, 1);
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      bus.clear_req = (i == 10);
      if (i == DEPTH - 1) idle();
      settle();
      chk("clr_w0_en", bus.W0_en, 1);
      chk("clr_w0_addr", bus.W0_addr, 64'(i));
      chk("clr_w0_data", bus.W0_data, 0);
      chk("clr_rd0_ready", bus.rd0_req_ready, 0);
      chk("clr_r0_en", bus.R0_en, 0);
      chk("clr_busy", bus.clear_busy, 1);
    end
    tick();
    settle();
    chk("run_clear_busy", bus.clear_busy, 0);
    chk("run_w0_en_idle", bus.W0_en, 0);
    chk("run_r0_en_idle", bus.R0_en, 0);
    chk("run_wr_ready", bus.wr_ready, 1);

    bus.rd0_req_valid = 1'b1;
    bus.rd0_req_addr  = 6'd0;
    settle();
    chk("rd_a0_ready", bus.rd0_req_ready, 1);
    chk("rd_a0_r0_en", bus.R0_en, 1);
    chk("rd_a0_r0_addr", bus.R0_addr, 0);
    chk("rd_a0_rd1_ready", bus.rd1_req_ready, 0);
    tick();
    chk("rd_a0_resp_valid", bus.rd0_resp_valid, 1);
    chk("rd_a0_resp_data", bus.rd0_resp_data, 0);
    chk("rd_a0_rd1_valid", bus.rd1_resp_valid, 0);
    chk("rd_a0_rd1_data", bus.rd1_resp_data, 0);
    idle();
    bus.rd1_req_valid = 1'b1;
    bus.rd1_req_addr  = 6'd47;
    settle();
    chk("rd_a47_ready", bus.rd1_req_ready, 1);
    chk("rd_a47_r0_addr", bus.R0_addr, 47);
    tick();
    chk("rd_a47_resp_valid", bus.rd1_resp_valid, 1);
    chk("rd_a47_resp_data", bus.rd1_resp_data, 0);
    chk("rd_a47_rd0_valid", bus.rd0_resp_valid, 0);
    chk("rd_a47_rd0_data", bus.rd0_resp_data, 0);

    idle();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd5;
    bus.wr_data  = BEEF;
    settle();
    chk("wr5_ready", bus.wr_ready, 1);
    chk("wr5_w0_en", bus.W0_en, 1);
    chk("wr5_w0_addr", bus.W0_addr, 5);
    chk("wr5_w0_data", bus.W0_data, BEEF);
    tick();
    idle();
    bus.rd0_req_valid = 1'b1;
    bus.rd0_req_addr  = 6'd5;
    settle();
    chk("rd5_ready", bus.rd0_req_ready, 1);
    tick();
    chk("rd5_resp_valid", bus.rd0_resp_valid, 1);
    chk("rd5_resp_data", bus.rd0_resp_data, BEEF);
    chk("rd5_rd1_valid", bus.rd1_resp_valid, 0);

    idle();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd1;
    bus.wr_data  = 64'h111;
    settle();
    chk("wr1_w0_en", bus.W0_en, 1);
    tick();
    bus.wr_addr = 6'd2;
    bus.wr_data = 64'h222;
    settle();
    chk("wr2_w0_addr", bus.W0_addr, 2);
    tick();
    idle();
    bus.rd0_req_valid = 1'b1;
    bus.rd0_req_addr  = 6'd1;
    bus.rd1_req_valid = 1'b1;
    bus.rd1_req_addr  = 6'd2;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        tick();
        chk("rr_rd0_resp_valid", bus.rd0_resp_valid, ((k - 1) % 2 == 0));
        chk("rr_rd0_resp_data", bus.rd0_resp_data, ((k - 1) % 2 == 0) ? 64'h111 : 64'h0);
        chk("rr_rd1_resp_valid", bus.rd1_resp_valid, ((k - 1) % 2 == 1));
        chk("rr_rd1_resp_data", bus.rd1_resp_data, ((k - 1) % 2 == 1) ? 64'h222 : 64'h0);
      end
      if (k < 6) begin
        settle();
        chk("rr_rd0_ready", bus.rd0_req_ready, (k % 2 == 0));
        chk("rr_rd1_ready", bus.rd1_req_ready, (k % 2 == 1));
        chk("rr_r0_addr", bus.R0_addr, (k % 2 == 0) ? 64'd1 : 64'd2);
      end else begin
        idle();
      end
    end

    bus.wr_valid      = 1'b1;
    bus.wr_addr       = 6'd10;
    bus.wr_data       = 64'h1234;
    bus.rd1_req_valid = 1'b1;
    bus.rd1_req_addr  = 6'd10;
    settle();
    chk("byp_rd1_ready", bus.rd1_req_ready, 1);
    chk("byp_w0_en", bus.W0_en, 1);
    chk("byp_r0_addr", bus.R0_addr, 10);
    tick();
    chk("byp_resp_valid", bus.rd1_resp_valid, 1);
    chk("byp_resp_data", bus.rd1_resp_data, 64'h1234);
    chk("byp_rd0_valid", bus.rd0_resp_valid, 0);

    idle();
    bus.rd0_req_valid = 1'b1;
    bus.rd0_req_addr  = 6'd50;
    bus.wr_valid      = 1'b1;
    bus.wr_addr       = 6'd60;
    bus.wr_data       = 64'hFFFF;
    settle();
    chk("oob_rd0_ready", bus.rd0_req_ready, 1);
    chk("oob_r0_en", bus.R0_en, 0);
    chk("oob_w0_en", bus.W0_en, 0);
    chk("oob_wr_ready", bus.wr_ready, 1);
    tick();
    chk("oob_resp_valid", bus.rd0_resp_valid, 1);
    chk("oob_resp_data", bus.rd0_resp_data, 0);

    idle();
    bus.rd0_req_valid = 1'b1;
    bus.rd0_req_addr  = 6'd5;
    bus.clear_req     = 1'b1;
    settle();
    chk("clrq_rd0_ready", bus.rd0_req_ready, 1);
    chk("clrq_r0_en", bus.R0_en, 1);
    chk("clrq_busy", bus.clear_busy, 0);
    tick();
    chk("clrq_resp_valid", bus.rd0_resp_valid, 1);
    chk("clrq_resp_data", bus.rd0_resp_data, BEEF);
    chk("clrq_busy_now", bus.clear_busy, 1);
    bus.clear_req     = 1'b0;
    bus.rd1_req_valid = 1'b1;
    bus.rd1_req_addr  = 6'd2;
    settle();
    chk("clr2_w0_en", bus.W0_en, 1);
    chk("clr2_w0_addr", bus.W0_addr, 0);
    chk("clr2_rd0_ready", bus.rd0_req_ready, 0);
    chk("clr2_rd1_ready", bus.rd1_req_ready, 0);
    chk("clr2_r0_en", bus.R0_en, 0);
    for (int j = 1; j <= 20; j++) begin
      tick();
      chk("clr2_resp_valid", bus.rd0_resp_valid, 0);
      settle();
      chk("clr2_w0_addr", bus.W0_addr, 64'(j));
      chk("clr2_ready", bus.rd0_req_ready, 0);
    end
    reset_n = 1'b0;
    settle();
    chk("mid_rst_w0_en", bus.W0_en, 0);
    chk("mid_rst_busy", bus.clear_busy, 1);
    chk("mid_rst_ready", bus.rd1_req_ready, 0);
    tick();
    reset_n = 1'b1;
    settle();
    chk("restart_w0_en", bus.W0_en, 1);
    chk("restart_w0_addr", bus.W0_addr, 0);
    for (int j = 1; j < DEPTH; j++) begin
      tick();
      if (j == DEPTH - 1) idle();
      settle();
      chk("restart_w0_en", bus.W0_en, 1);
      chk("restart_w0_addr", bus.W0_addr, 64'(j));
    end
    tick();
    settle();
    chk("restart_done_busy", bus.clear_busy, 0);
    bus.rd0_req_valid = 1'b1;
    bus.rd0_req_addr  = 6'd5;
    settle();
    chk("post_clr_ready", bus.rd0_req_ready, 1);
    tick();
    chk("post_clr_resp_valid", bus.rd0_resp_valid, 1);
    chk("post_clr_resp_data", bus.rd0_resp_data, 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_1r1w_ctrl.md
Name: mem_1r1w_ctrl

Overview:
Controller in front of one 1R1W synchronous SRAM macro wrapper (default 48x64, 1-cycle read latency). It shares the single read port between two requesters with round-robin arbitration and routes each response back to its owner. It owns the write port and runs a zero-fill clear sequence after reset or on request. It sits between pipeline clients and the lowered memory instance; the macro's R0_clk/W0_clk are tied to this block's clock at integration.

Parameters:
DEPTH, 48, number of valid words
WIDTH, 64, data width in bits
ADDR_W, 6, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clock  input  1  single clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
clear_req  input  1  single-cycle pulse; starts zero-fill when idle
clear_busy  output  1  high while zero-fill runs
rd0_req_valid  input  1  requester 0 read request
rd0_req_ready  output  1  requester 0 grant, combinational
rd0_req_addr  input  ADDR_W  requester 0 address
rd0_resp_valid  output  1  requester 0 data valid, one cycle after grant
rd0_resp_data  output  WIDTH  requester 0 read data
rd1_req_valid / rd1_req_ready / rd1_req_addr / rd1_resp_valid / rd1_resp_data  same as rd0_*, for requester 1
wr_valid  input  1  write request
wr_ready  output  1  write accepted this cycle
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
R0_addr  output  ADDR_W  to macro read address
R0_en  output  1  to macro read enable
R0_data  input  WIDTH  from macro; valid one cycle after R0_en
W0_addr  output  ADDR_W  to macro write address
W0_en  output  1  to macro write enable
W0_data  output  WIDTH  to macro write data

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clr_cnt=0, rr_ptr=0 (requester 0 favoured), clear_busy=1. Resp valids and bypass/oob flags are 0. All *_ready, R0_en and W0_en are 0 while reset_n is low.
- CLEAR: each cycle W0_en=1, W0_addr=clr_cnt, W0_data=0, clr_cnt+1. After writing DEPTH-1, the next state is RUN. Total DEPTH cycles. Readies are 0 and R0_en=0 throughout. clear_req is ignored (no restart). Reset mid-clear restarts from address 0.
- RUN: clear_busy=0. clear_req=1 moves to CLEAR next cycle with clr_cnt=0. That cycle still arbitrates normally.
- Write in RUN: wr_ready=1 and W0_en = wr_valid && (wr_addr < DEPTH), with W0_addr/W0_data passed through. An out-of-range write is accepted and dropped.
- Read arbitration in RUN: at most one grant per cycle. If only one requester is valid, it is granted. If both are valid, rr_ptr picks the winner and rr_ptr moves to the other requester. rr_ptr changes only on a contended grant.
- On a grant: R0_en=1 and R0_addr = winner's address. rdX_req_ready = grant, combinational from valid.
- Response: exactly 1 cycle after the grant, only the granted port's resp_valid=1. resp_data is R0_data, with these overrides:
  - Out-of-range read address: data forced to 0 and R0_en stays 0 (registered oob flag).
  - Read and write to the same in-range address in the same cycle: data returns that cycle's wr_data (registered bypass); the macro output is not used.
- A read granted in the last RUN cycle before CLEAR still returns its response. A read landing on an address the clear has already written returns that data; no squash.
- resp_data is 0 whenever resp_valid=0.

Test Plan:
- Release reset, no stimulus -> W0_en high for exactly 48 cycles, addresses 0..47, data 0. clear_busy drops on cycle 48. Reads of addr 0 and 47 then return 0.
- Write addr 5 = 0xDEADBEEF_CAFEF00D, then rd0 read addr 5 -> rd0_resp_valid 1 cycle after grant with that data; rd1_resp_valid stays 0.
- Both requesters valid for 6 cycles, addresses 1 and 2 -> grants alternate 0,1,0,1,0,1. Each response appears only on the owner's port.
- Same cycle: write addr 10 = 0x1234 and rd1 reads addr 10 -> rd1_resp_data = 0x1234 next cycle.
- rd0 reads addr 50 and a write to addr 60 -> response 0; W0_en and R0_en stay low; wr_ready=1.
- clear_req while a read is granted -> response delivered next cycle. Then 48 clear cycles with readies low. Assert reset_n low at clear cycle 20 -> the clear restarts at addr 0 after release.
